// File: rtl/dpcm_player.sv
// dpcm_player: delta-modulation sample channel; bytes fetched over req/ack into a prefetch FIFO, shifted out as +/-STEP level changes. Optional DPCM_DIRECT_LOAD_EN enables reg_sel 1 direct level loads.
// Latency: first mem_req on the clk edge that samples start; one byte per 2 clk with mem_ack high; level moves one STEP per rate tick.
// Backpressure: no request is issued while FIFO occupancy plus the outstanding request would exceed FIFO_DEPTH; mem_req holds until mem_ack.
module dpcm_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] head_dat,
    output logic [4:0]       count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 5'd1;
            else if (pop && !push) count <= count - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module dpcm_player #(
    parameter int FIFO_DEPTH = 1,
    parameter int OUT_WIDTH  = 7,
    parameter int STEP       = 2
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 cpu_clk_en,
    input  logic                 reg_wr,
    input  logic [1:0]           reg_sel,
    input  logic [7:0]           reg_wdata,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 irq_clr,
    output logic                 mem_req,
    output logic [15:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_data,
    output logic                 active,
    output logic                 irq_l,
    output logic [OUT_WIDTH-1:0] vol_out
);
    localparam logic [4:0]           DEPTH_W = 5'(FIFO_DEPTH);
    localparam logic [OUT_WIDTH-1:0] STEP_W  = OUT_WIDTH'(STEP);
    localparam logic [OUT_WIDTH-1:0] UP_MAX  = OUT_WIDTH'((1 << OUT_WIDTH) - 1 - STEP);

    function automatic logic [8:0] rate_period(input logic [3:0] r);
        case (r)
            4'd0:    rate_period = 9'd428;
            4'd1:    rate_period = 9'd380;
            4'd2:    rate_period = 9'd340;
            4'd3:    rate_period = 9'd320;
            4'd4:    rate_period = 9'd286;
            4'd5:    rate_period = 9'd254;
            4'd6:    rate_period = 9'd226;
            4'd7:    rate_period = 9'd214;
            4'd8:    rate_period = 9'd190;
            4'd9:    rate_period = 9'd160;
            4'd10:   rate_period = 9'd142;
            4'd11:   rate_period = 9'd128;
            4'd12:   rate_period = 9'd106;
            4'd13:   rate_period = 9'd84;
            4'd14:   rate_period = 9'd72;
            default: rate_period = 9'd54;
        endcase
    endfunction

    logic        irq_en, loop_en;
    logic [3:0]  rate;
    logic [7:0]  addr_reg, len_reg;
    logic [15:0] cur_addr;
    logic [11:0] bytes_rem;
    logic        irq_flag;
    logic [8:0]  timer;
    logic [7:0]  shift_reg;
    logic [2:0]  bits_left;
    logic        silence;
    logic [7:0]  fifo_head;
    logic [4:0]  fifo_count;
    logic        unused_bits;

    logic        start_go, ack_hit, last_byte, issue, tick, pop, irq_set, irq_clear;
    logic [15:0] start_addr, next_addr;
    logic [11:0] start_len;
    logic [OUT_WIDTH-1:0] vol_next;

    assign unused_bits = ^reg_wdata[5:4];

    assign active     = (bytes_rem != 12'd0);
    assign irq_l      = ~irq_flag;
    assign start_go   = start && !active;
    assign start_addr = 16'hC000 + {2'b00, addr_reg, 6'b000000};
    assign start_len  = {len_reg, 4'b0000} + 12'd1;
    assign next_addr  = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + 16'd1;
    assign ack_hit    = mem_req && mem_ack;
    assign last_byte  = ack_hit && !stop && (bytes_rem == 12'd1);
    // Outstanding request is always zero when issuing, so occupancy alone bounds the FIFO.
    assign issue      = !mem_req && !stop && (fifo_count < DEPTH_W) && (start_go || active);
    assign irq_set    = last_byte && !loop_en && irq_en;
    assign irq_clear  = irq_clr || (reg_wr && reg_sel == 2'd0 && !reg_wdata[7]);
    assign tick       = cpu_clk_en && (timer == 9'd0);
    assign pop        = tick && (bits_left == 3'd0) && (fifo_count != 5'd0);

    dpcm_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .push     (ack_hit),
        .pop      (pop),
        .push_dat (mem_data),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            irq_en   <= 1'b0;
            loop_en  <= 1'b0;
            rate     <= 4'd0;
            addr_reg <= 8'd0;
            len_reg  <= 8'd0;
        end else if (reg_wr) begin
            case (reg_sel)
                2'd0: begin
                    irq_en  <= reg_wdata[7];
                    loop_en <= reg_wdata[6];
                    rate    <= reg_wdata[3:0];
                end
                2'd2:    addr_reg <= reg_wdata;
                2'd3:    len_reg  <= reg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mem_req   <= 1'b0;
            mem_addr  <= 16'd0;
            cur_addr  <= 16'd0;
            bytes_rem <= 12'd0;
            irq_flag  <= 1'b0;
        end else begin
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= start_go ? start_addr : cur_addr;
            end else if (ack_hit) begin
                mem_req <= 1'b0;
            end

            // A stale ack after stop still pushes its byte but leaves the counter at zero.
            if (stop) begin
                bytes_rem <= 12'd0;
            end else if (start_go) begin
                bytes_rem <= start_len;
                cur_addr  <= start_addr;
            end else if (ack_hit && active) begin
                if (last_byte && loop_en) begin
                    bytes_rem <= start_len;
                    cur_addr  <= start_addr;
                end else begin
                    bytes_rem <= bytes_rem - 12'd1;
                    cur_addr  <= next_addr;
                end
            end

            if (irq_set)        irq_flag <= 1'b1;
            else if (irq_clear) irq_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            timer <= 9'd0;
        end else if (cpu_clk_en) begin
            if (timer == 9'd0) timer <= rate_period(rate) - 9'd1;
            else               timer <= timer - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            shift_reg <= 8'd0;
            bits_left <= 3'd0;
            silence   <= 1'b1;
        end else if (tick) begin
            if (bits_left == 3'd0) begin
                bits_left <= 3'd7;
                if (fifo_count != 5'd0) begin
                    shift_reg <= fifo_head;
                    silence   <= 1'b0;
                end else begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    silence   <= 1'b1;
                end
            end else begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bits_left <= bits_left - 3'd1;
            end
        end
    end

    always_comb begin
        vol_next = vol_out;
        if (tick && !silence) begin
            if (shift_reg[0]) begin
                if (vol_out <= UP_MAX) vol_next = vol_out + STEP_W;
            end else begin
                if (vol_out >= STEP_W) vol_next = vol_out - STEP_W;
            end
        end
`ifdef DPCM_DIRECT_LOAD_EN
        if (reg_wr && reg_sel == 2'd1) vol_next = OUT_WIDTH'(reg_wdata[6:0]) << (OUT_WIDTH - 7);
`endif
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) vol_out <= '0;
        else        vol_out <= vol_next;
    end
endmodule

// File: tb/tb_dpcm_player.sv
// Directed bench for dpcm_player (FIFO_DEPTH 4, OUT_WIDTH 7, STEP 2); fetch addresses are scoreboarded against a queue.
module tb_dpcm_player;
    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       cpu_clk_en = 1'b0;
    logic       reg_wr = 1'b0;
    logic [1:0] reg_sel = 2'd0;
    logic [7:0] reg_wdata = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       irq_clr = 1'b0;
    logic       mem_req;
    logic [15:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = 8'd0;
    logic       active;
    logic       irq_l;
    logic [6:0] vol_out;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_addr, prev_addr;
    logic [6:0]  prev_vol;

    dpcm_player #(.FIFO_DEPTH(4), .OUT_WIDTH(7), .STEP(2)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .cpu_clk_en (cpu_clk_en),
        .reg_wr     (reg_wr),
        .reg_sel    (reg_sel),
        .reg_wdata  (reg_wdata),
        .start      (start),
        .stop       (stop),
        .irq_clr    (irq_clr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .active     (active),
        .irq_l      (irq_l),
        .vol_out    (vol_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_l = 1'b0; cpu_clk_en = 1'b0; reg_wr = 1'b0; start = 1'b0; stop = 1'b0;
        irq_clr = 1'b0; mem_ack = 1'b0; mem_data = 8'd0;
        exp_q.delete();
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
        reg_sel = sel; reg_wdata = d; reg_wr = 1'b1;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts acks with mem_ack held high, checks each address against the queue and, if asked, each level change.
    task automatic watch(input int cycles, input int stop_after, inout int acks, input bit vol_up);
        for (int c = 0; c < cycles && acks < stop_after; c++) begin
            if (mem_req && mem_ack) begin
                if (exp_q.size() > 0) chk("ack_addr", mem_addr, exp_q.pop_front());
                else                  chk("extra_ack", mem_addr, 32'hDEAD);
                prev_addr = last_addr;
                last_addr = mem_addr;
                acks++;
            end
            if (vol_up && vol_out !== prev_vol) chk("vol_step", vol_out, prev_vol + 7'd2);
            prev_vol = vol_out;
            @(negedge clk);
        end
    endtask

    task automatic ack_one();
        int n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", mem_req, 1);
        if (exp_q.size() > 0) chk("ack_addr", mem_addr, exp_q.pop_front());
        else                  chk("extra_req", mem_addr, 32'hDEAD);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("loop_active", active, 1);
    endtask

    initial begin
        int acks;
        logic [15:0] a;

        // Reset values, then default registers: one byte at C000.
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_active", active, 0);
        chk("rst_irq", irq_l, 1);
        chk("rst_vol", vol_out, 0);
        do_reset();
        mem_ack = 1'b1;
        pulse_start();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 16'hC000);
        chk("t1_active", active, 1);
        @(negedge clk);
        chk("t1_req_drop", mem_req, 0);
        chk("t1_active_drop", active, 0);
        repeat (10) @(negedge clk);
        chk("t1_req_idle", mem_req, 0);
        chk("t1_irq", irq_l, 1);

        // Fetch and output: 17 bytes of FF from C040, level climbs to 126.
        do_reset();
        reg_write(2'd0, 8'h8F);
        reg_write(2'd2, 8'h01);
        reg_write(2'd3, 8'h01);
        for (int i = 0; i < 17; i++) exp_q.push_back(16'hC040 + 16'(i));
        mem_data = 8'hFF; mem_ack = 1'b1; cpu_clk_en = 1'b1;
        prev_vol = vol_out; acks = 0;
        pulse_start();
        watch(8000, 17, acks, 1'b1);
        chk("t2_acks", acks, 17);
        chk("t2_irq_low", irq_l, 0);
        chk("t2_active", active, 0);
        watch(1000, 99, acks, 1'b1);
        chk("t2_no_extra", acks, 17);
        chk("t2_vol_sat", vol_out, 126);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("t2_irq_clr", irq_l, 1);

        // Backpressure: four fetches fill the FIFO, one pop frees one slot.
        do_reset();
        reg_write(2'd3, 8'h01);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hC000 + 16'(i));
        mem_ack = 1'b1; acks = 0;
        pulse_start();
        watch(60, 99, acks, 1'b0);
        chk("t3_acks", acks, 4);
        chk("t3_req_blocked", mem_req, 0);
        chk("t3_active", active, 1);
        exp_q.push_back(16'hC004);
        cpu_clk_en = 1'b1;
        @(negedge clk);
        cpu_clk_en = 1'b0;
        watch(20, 99, acks, 1'b0);
        chk("t3_after_pop", acks, 5);
        chk("t3_req_blocked2", mem_req, 0);

        // Loop with len 0 refetches C000; stop with a delayed ack still completes.
        do_reset();
        reg_write(2'd0, 8'hC0);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'hC000);
            ack_one();
        end
        @(negedge clk);
        chk("t4_req4", mem_req, 1);
        chk("t4_addr4", mem_addr, 16'hC000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4_stop_inactive", active, 0);
        for (int i = 0; i < 2; i++) begin
            chk("t4_req_hold", mem_req, 1);
            @(negedge clk);
        end
        chk("t4_req_hold3", mem_req, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t4_req_done", mem_req, 0);
        repeat (8) @(negedge clk);
        chk("t4_req_quiet", mem_req, 0);
        chk("t4_no_irq", irq_l, 1);

        // Address wrap: 65 bytes from FFC0 end at FFFF then 8000.
        do_reset();
        reg_write(2'd0, 8'h8F);
        reg_write(2'd2, 8'hFF);
        reg_write(2'd3, 8'h04);
        a = 16'hFFC0;
        for (int i = 0; i < 65; i++) begin
            exp_q.push_back(a);
            a = (a == 16'hFFFF) ? 16'h8000 : a + 16'd1;
        end
        mem_data = 8'h00; mem_ack = 1'b1; cpu_clk_en = 1'b1; acks = 0;
        pulse_start();
        watch(30000, 65, acks, 1'b0);
        chk("t5_acks", acks, 65);
        chk("t5_prev_addr", prev_addr, 16'hFFFF);
        chk("t5_last_addr", last_addr, 16'h8000);
        chk("t5_irq_low", irq_l, 0);
        chk("t5_vol_floor", vol_out, 0);
        reg_write(2'd0, 8'h0F);
        chk("t5_irq_ctrl_clr", irq_l, 1);

        // Silence with empty FIFO; direct level load when built in.
        do_reset();
        reg_write(2'd0, 8'h0F);
        reg_write(2'd1, 8'h40);
`ifdef DPCM_DIRECT_LOAD_EN
        chk("t6_direct", vol_out, 64);
`else
        chk("t6_direct_ignored", vol_out, 0);
`endif
        cpu_clk_en = 1'b1;
        repeat (16 * 54 + 5) @(negedge clk);
`ifdef DPCM_DIRECT_LOAD_EN
        chk("t6_silence", vol_out, 64);
`else
        chk("t6_silence", vol_out, 0);
`endif
        chk("t6_no_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
